vram_arbiter: RTL and testbench

Owns the 320×240×12-bit frame buffer behind the VGA scan-out and shares its single BRAM port between two users: display refresh and a host (drawing engine or CPU) request port. Display reads are strictly guaranteed; host reads and writes use the remaining cycles. The block sits between `vga_controller` (p_tick/x/y/video_on) and the RGB buffer register in `top`, replacing `pixel_generation` as the RGB source.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vram_sp.sv | 27 ++
 rtl/vram_arbiter.sv | 105 ++++++++++
 tb/tb_vram_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/frame-buffer definitions: geometry, slot ownership, display timing.
package vga_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 12;

  // Visible area produced by vga_controller; the frame buffer is 2x upscaled into it.
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  // Owner of the single BRAM port for one clk cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    HOST_RD = 2'd2,
    HOST_WR = 2'd3
  } slot_t;

endpackage

// File: rtl/vram_sp.sv
// Inferred single-port frame-buffer BRAM with one-cycle registered read.
module vram_sp #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 76800
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Read-first port: a write cycle also refreshes rdata, but no owner consumes it.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Frame-buffer owner: shares one BRAM port between guaranteed scan-out reads
// and a host read/write port, routing returned data by a pipelined owner tag.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int FB_W   = vga_pkg::FB_W,
  parameter int FB_H   = vga_pkg::FB_H,
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [DATA_W-1:0] pix_rgb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  logic              scan_slot;
  logic              host_accept;
  logic              host_in_range;
  slot_t             slot;
  logic [ADDR_W-1:0] row_idx;
  logic [ADDR_W-1:0] col_idx;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic              bram_we;
  logic [DATA_W-1:0] bram_rdata;
  slot_t             tag_q1;
  slot_t             tag_q2;
  logic              oob_q1;

  assign scan_slot     = p_tick & video_on;
  assign req_ready     = ~scan_slot;
  assign host_accept   = req_valid & req_ready;
  assign host_in_range = req_addr < ADDR_W'(FB_W * FB_H);

  // Row * 320 as two shifts and an add; x/y are taken unguarded during active video.
  assign row_idx   = ADDR_W'(y >> 1);
  assign col_idx   = ADDR_W'(x >> 1);
  assign scan_addr = (row_idx << 8) + (row_idx << 6) + col_idx;

  // Pick this cycle's port owner: scan first, then an accepted host transfer.
  always_comb begin
    slot = IDLE;
    if (scan_slot) begin
      slot = SCAN;
    end else if (host_accept) begin
      slot = req_we ? HOST_WR : HOST_RD;
    end
  end

  // Out-of-range host accesses still occupy a slot but never touch the BRAM.
  assign bram_addr = scan_slot ? scan_addr : req_addr;
  assign bram_en   = scan_slot | (host_accept & host_in_range);
  assign bram_we   = (slot == HOST_WR) & host_in_range;

  vram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FB_W * FB_H)
  ) u_vram (
    .clk   (clk_100MHz),
    .en    (bram_en),
    .we    (bram_we),
    .addr  (bram_addr),
    .wdata (req_wdata),
    .rdata (bram_rdata)
  );

  // Tag pipeline plus output registers; returned BRAM data is steered by the stage-1 tag.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      tag_q1    <= IDLE;
      tag_q2    <= IDLE;
      oob_q1    <= 1'b0;
      pix_rgb   <= '0;
      rsp_rdata <= '0;
    end else begin
      tag_q1 <= slot;
      oob_q1 <= ~host_in_range;
      tag_q2 <= tag_q1;
      if (tag_q1 == SCAN) begin
        pix_rgb <= bram_rdata;
      end else if (p_tick & ~video_on) begin
        pix_rgb <= '0;
      end
      if (tag_q1 == HOST_RD) begin
        rsp_rdata <= oob_q1 ? '0 : bram_rdata;
      end
    end
  end

  assign rsp_valid = (tag_q2 == HOST_RD);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset state, scan/host sharing, read latency,
// out-of-range accesses and reset while a read is in flight.
module tb_vram_arbiter;

  logic        clk_100MHz;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] pix_rgb;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [16:0] req_addr;
  logic [11:0] req_wdata;
  logic        rsp_valid;
  logic [11:0] rsp_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  vram_arbiter dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .pix_rgb    (pix_rgb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata)
  );

  // 100 MHz free-running clock
  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic apply_stimulus(input logic pt, input logic vo, input logic [9:0] xx,
                                input logic [9:0] yy, input logic rv, input logic we,
                                input logic [16:0] addr, input logic [11:0] wdata);
    p_tick    = pt;
    video_on  = vo;
    x         = xx;
    y         = yy;
    req_valid = rv;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic host_write(input logic [16:0] addr, input logic [11:0] data);
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, addr, data);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    tick();
    tick();
    check_output("reset_pix_rgb",   16'(pix_rgb),   16'h000);
    check_output("reset_rsp_valid", 16'(rsp_valid), 16'h0);
    check_output("reset_rsp_rdata", 16'(rsp_rdata), 16'h000);
    check_output("reset_req_ready", 16'(req_ready), 16'h1);
    reset = 1'b1;
    tick();
    check_output("idle_pix_rgb",   16'(pix_rgb),   16'h000);
    check_output("idle_rsp_valid", 16'(rsp_valid), 16'h0);
    check_output("idle_req_ready", 16'(req_ready), 16'h1);

    // preload during blanking
    host_write(17'd322, 12'hABC);
    host_write(17'd100, 12'h123);
    host_write(17'd101, 12'h456);
    host_write(17'd102, 12'h789);
    host_write(17'd0,   12'h5A5);

    // scan of (4,2) -> addr 322 while a host write waits out the scan slot
    apply_stimulus(1'b1, 1'b1, 10'd4, 10'd2, 1'b1, 1'b1, 17'd5, 12'h777);
    #1;
    check_output("ready_low_on_scan", 16'(req_ready), 16'h0);
    tick();
    apply_stimulus(1'b0, 1'b1, 10'd5, 10'd2, 1'b1, 1'b1, 17'd5, 12'h777);
    #1;
    check_output("ready_high_after_scan", 16'(req_ready), 16'h1);
    check_output("pix_not_yet", 16'(pix_rgb), 16'h000);
    tick();
    apply_stimulus(1'b0, 1'b1, 10'd5, 10'd2, 1'b0, 1'b0, 17'd0, 12'h000);
    check_output("scan_pix_322", 16'(pix_rgb), 16'hABC);
    tick();
    check_output("pix_holds", 16'(pix_rgb), 16'hABC);

    // blanking p_tick forces black
    apply_stimulus(1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    check_output("blank_black", 16'(pix_rgb), 16'h000);

    // single read of addr 100
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd100, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    check_output("rd_n1_no_valid", 16'(rsp_valid), 16'h0);
    tick();
    check_output("rd_n2_valid", 16'(rsp_valid), 16'h1);
    check_output("rd_n2_data",  16'(rsp_rdata), 16'h123);
    tick();
    check_output("rd_n3_no_valid", 16'(rsp_valid), 16'h0);

    // three back-to-back reads
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd100, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd101, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd102, 12'h000);
    check_output("b2b_0_valid", 16'(rsp_valid), 16'h1);
    check_output("b2b_0_data",  16'(rsp_rdata), 16'h123);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    check_output("b2b_1_valid", 16'(rsp_valid), 16'h1);
    check_output("b2b_1_data",  16'(rsp_rdata), 16'h456);
    tick();
    check_output("b2b_2_valid", 16'(rsp_valid), 16'h1);
    check_output("b2b_2_data",  16'(rsp_rdata), 16'h789);
    tick();
    check_output("b2b_end", 16'(rsp_valid), 16'h0);

    // the write delayed by the scan slot landed
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd5, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    tick();
    check_output("delayed_wr_data", 16'(rsp_rdata), 16'h777);

    // out-of-range write dropped, read returns 0, addr 0 untouched
    host_write(17'd76800, 12'hFFF);
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd76800, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd0, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    check_output("oob_rd_valid", 16'(rsp_valid), 16'h1);
    check_output("oob_rd_data",  16'(rsp_rdata), 16'h000);
    tick();
    check_output("addr0_valid", 16'(rsp_valid), 16'h1);
    check_output("addr0_data",  16'(rsp_rdata), 16'h5A5);

    // read immediately after a write to the same address
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 17'd200, 12'h3C3);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd200, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    tick();
    check_output("raw_valid", 16'(rsp_valid), 16'h1);
    check_output("raw_data",  16'(rsp_rdata), 16'h3C3);

    // reset while a read is in flight
    apply_stimulus(1'b1, 1'b1, 10'd4, 10'd2, 1'b0, 1'b0, 17'd0, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b1, 10'd5, 10'd2, 1'b0, 1'b0, 17'd0, 12'h000);
    tick();
    check_output("pre_reset_pix", 16'(pix_rgb), 16'hABC);
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 17'd100, 12'h000);
    tick();
    apply_stimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    reset = 1'b0;
    #1;
    check_output("midrst_rsp_valid", 16'(rsp_valid), 16'h0);
    check_output("midrst_pix",       16'(pix_rgb),   16'h000);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output("inrst_rsp_valid", 16'(rsp_valid), 16'h0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("postrst_rsp_valid", 16'(rsp_valid), 16'h0);
    end
    check_output("postrst_pix", 16'(pix_rgb), 16'h000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
